// File: rtl/pipe_pkg.sv
// Shared state encoding and default field widths for the pipeline stage register.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 5;
    localparam int CTRL_W_DEF = 4;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Perf counters stick at all-ones rather than wrapping to a misleading small value.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Parametrised payload register with load enable and synchronous clear.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // NOTE: clear beats load so a reset in the same cycle as an accept leaves zeros.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage (main + skid registers).
// Optional bubble counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rb,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ram_ctrl,
    input  logic              in_l,
    input  logic              in_rf_le,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rb,
    output logic [DATA_W-1:0] out_alu,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ram_ctrl,
    output logic              out_l,
    output logic              out_rf_le,
    output logic [31:0]       bubble_cnt
);

    localparam int PW = 2 * DATA_W + RD_W + CTRL_W + 2;

    logic [1:0]        state_q, state_d;
    logic              in_ready_q;
    logic              main_ld, skid_ld;
    logic              in_hs, out_hs;
    logic [PW-1:0]     in_pl, main_d, main_q, skid_q;
    logic [CTRL_W-1:0] ram_ctrl_raw;
    logic              l_raw, rf_le_raw;

    assign in_pl     = {in_rb, in_alu, in_rd, in_ram_ctrl, in_l, in_rf_le};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign in_hs     = in_valid && in_ready_q;
    assign out_hs    = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_hs) begin
                        main_ld = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_hs && out_hs) begin
                        main_ld = 1'b1;
                    end else if (in_hs) begin
                        skid_ld = 1'b1;
                        state_d = ST_FULL;
                    end else if (out_hs) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_hs) begin
                        main_ld = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // In FULL the only legal main refill is the older skid entry, keeping order.
    assign main_d = (state_q == ST_FULL) ? skid_q : in_pl;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk   (clk),
        .clr_i (Reset),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .clk   (clk),
        .clr_i (Reset),
        .ld_i  (skid_ld),
        .d_i   (in_pl),
        .q_o   (skid_q)
    );

    assign {out_rb, out_alu, out_rd, ram_ctrl_raw, l_raw, rf_le_raw} = main_q;

    // Side-effecting controls must never leak out of an empty stage.
    assign out_ram_ctrl = out_valid ? ram_ctrl_raw : '0;
    assign out_l        = out_valid && l_raw;
    assign out_rf_le    = out_valid && rf_le_raw;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] bubble_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            bubble_q <= '0;
        end else if (!out_valid) begin
            bubble_q <= sat_inc(bubble_q);
        end
    end

    assign bubble_cnt = bubble_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CTRL_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0] rb;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
        logic              l;
        logic              le;
    } item_t;

    logic              clk = 1'b0;
    logic              Reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_rb, in_alu, out_rb, out_alu;
    logic [RD_W-1:0]   in_rd, out_rd;
    logic [CTRL_W-1:0] in_ram_ctrl, out_ram_ctrl;
    logic              in_l, in_rf_le, out_l, out_rf_le;
    logic [31:0]       bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rb        (in_rb),
        .in_alu       (in_alu),
        .in_rd        (in_rd),
        .in_ram_ctrl  (in_ram_ctrl),
        .in_l         (in_l),
        .in_rf_le     (in_rf_le),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rb       (out_rb),
        .out_alu      (out_alu),
        .out_rd       (out_rd),
        .out_ram_ctrl (out_ram_ctrl),
        .out_l        (out_l),
        .out_rf_le    (out_rf_le),
        .bubble_cnt   (bubble_cnt)
    );

    // Reference model: FIFO of held entries (capacity 2) plus the last entry shown.
    item_t       mq[$];
    item_t       last_m;
    logic [31:0] bub_m;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic item_t rand_item();
        item_t it;
        it.rb   = $urandom();
        it.alu  = $urandom();
        it.rd   = RD_W'($urandom());
        it.ctrl = CTRL_W'($urandom());
        it.l    = 1'($urandom());
        it.le   = 1'($urandom());
        return it;
    endfunction

    function automatic item_t alu_item(input logic [DATA_W-1:0] a);
        item_t it;
        it      = rand_item();
        it.alu  = a;
        it.ctrl = 4'hF;
        it.le   = 1'b1;
        return it;
    endfunction

    task automatic check_outputs();
        logic has;
        has = (mq.size() != 0);
        check("out_valid", 64'(out_valid), 64'(has));
        check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        check("out_rb", 64'(out_rb), 64'(last_m.rb));
        check("out_alu", 64'(out_alu), 64'(last_m.alu));
        check("out_rd", 64'(out_rd), 64'(last_m.rd));
        check("out_ram_ctrl", 64'(out_ram_ctrl), has ? 64'(mq[0].ctrl) : 64'd0);
        check("out_l", 64'(out_l), has ? 64'(mq[0].l) : 64'd0);
        check("out_rf_le", 64'(out_rf_le), has ? 64'(mq[0].le) : 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'(bub_m));
`else
        check("bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic step(input logic rst, input logic fl, input logic iv, input item_t it,
                        input logic ordy);
        logic acc, con;
        Reset       = rst;
        flush       = fl;
        in_valid    = iv;
        in_rb       = it.rb;
        in_alu      = it.alu;
        in_rd       = it.rd;
        in_ram_ctrl = it.ctrl;
        in_l        = it.l;
        in_rf_le    = it.le;
        out_ready   = ordy;
        @(posedge clk);
        acc = iv && (mq.size() < 2);
        con = ordy && (mq.size() != 0);
        if (rst) begin
            bub_m  = '0;
            mq.delete();
            last_m = '0;
        end else begin
            if (mq.size() == 0 && bub_m != 32'hFFFF_FFFF) bub_m++;
            if (fl) begin
                mq.delete();
            end else begin
                if (con) void'(mq.pop_front());
                if (acc) mq.push_back(it);
            end
        end
        if (mq.size() != 0) last_m = mq[0];
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, rand_item(), ordy);
    endtask

    initial begin
        last_m = '0;
        bub_m  = '0;

        // Reset state, then single entry with 1-cycle latency
        step(1'b1, 1'b0, 1'b1, rand_item(), 1'b1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_alu", 64'(out_alu), 64'd0);
        step(1'b0, 1'b0, 1'b1, alu_item(32'h0000_00AA), 1'b1);
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_alu", 64'(out_alu), 64'h0000_00AA);

        // Back-to-back A, B with stalled consumer fills the skid
        step(1'b1, 1'b0, 1'b0, rand_item(), 1'b0);
        step(1'b0, 1'b0, 1'b1, alu_item(32'd1), 1'b0);
        step(1'b0, 1'b0, 1'b1, alu_item(32'd2), 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head", 64'(out_alu), 64'd1);
        step(1'b0, 1'b0, 1'b1, alu_item(32'd3), 1'b1);
        check("drain_b", 64'(out_alu), 64'd2);
        check("drain_b_valid", 64'(out_valid), 64'd1);
        idle(1'b1);
        check("drain_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a concurrent offer
        step(1'b0, 1'b0, 1'b1, alu_item(32'd4), 1'b0);
        step(1'b0, 1'b0, 1'b1, alu_item(32'd5), 1'b0);
        step(1'b0, 1'b1, 1'b1, alu_item(32'd6), 1'b0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_rf_le", 64'(out_rf_le), 64'd0);
        check("flush_ram_ctrl", 64'(out_ram_ctrl), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);

        // Streaming 100 entries: ordered, no bubbles after the first
        step(1'b1, 1'b0, 1'b0, rand_item(), 1'b1);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b1, alu_item(32'(1000 + i)), 1'b1);
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_order", 64'(out_alu), 64'(1000 + i));
        end

        // Reset mid-stream while ONE
        idle(1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        step(1'b1, 1'b0, 1'b1, alu_item(32'd77), 1'b0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_alu", 64'(out_alu), 64'd0);
        check("mid_rst_rb", 64'(out_rb), 64'd0);
        check("mid_rst_rd", 64'(out_rd), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);

        // Ten idle cycles after reset
        for (int i = 0; i < 10; i++) idle(1'($urandom()));
`ifdef PIPE_STAGE_PERF_EN
        check("bubble_10", 64'(bubble_cnt), 64'd10);
`else
        check("bubble_off", 64'(bubble_cnt), 64'd0);
`endif

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 23) == 0),
                 1'($urandom_range(0, 3) != 0), rand_item(),
                 1'($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
